// File: rtl/ofs_fim_axis_arb_pkg.sv
// Shared types, limits and index arithmetic for the AXI-S round-robin arbiter.
package ofs_fim_axis_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // (a + b) mod n for operands already in [0, n); avoids a general divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-Stream bundle used between the PCIe subsystem and FIM logic.
interface pcie_ss_axis_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 10
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic [USER_W-1:0]     tuser_vendor;

  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
  modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/ofs_fim_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module ofs_fim_rr_arbiter
  import ofs_fim_axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] winner
);

  // Walk the requesters starting at ptr; the first one found wins.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PTR_W'(wrap_add(int'(ptr), k, NUM_PORTS));
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofs_fim_axis_rr_arb.sv
// Packet-locked round-robin AXI-S arbiter: N requester streams onto one output.
module ofs_fim_axis_rr_arb
  import ofs_fim_axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 512,
  parameter int USER_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcie_ss_axis_if.sink          axis_s [NUM_PORTS],
  pcie_ss_axis_if.source        axis_m,
  output logic [NUM_PORTS-1:0]  grant,
  output logic                  busy
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner_idx;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] last_vec;
  logic [NUM_PORTS-1:0] winner;
  logic [DATA_W-1:0]    data_arr [NUM_PORTS];
  logic [KEEP_W-1:0]    keep_arr [NUM_PORTS];
  logic [USER_W-1:0]    user_arr [NUM_PORTS];

  logic                 m_valid;
  logic                 m_last;
  logic                 m_ready;
  logic [DATA_W-1:0]    m_data;
  logic [KEEP_W-1:0]    m_keep;
  logic [USER_W-1:0]    m_user;
  logic                 pkt_done;

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
    $fatal(1, "ofs_fim_axis_rr_arb: NUM_PORTS=%0d outside 2..%0d", NUM_PORTS, MAX_PORTS);
  end

  if ($bits(axis_m.tdata) != DATA_W || $bits(axis_m.tuser_vendor) != USER_W) begin : g_bad_m_if
    $fatal(1, "ofs_fim_axis_rr_arb: axis_m width does not match DATA_W/USER_W");
  end

  // Flatten the interface array so the rest of the logic can use variable indices.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    if ($bits(axis_s[gi].tdata) != DATA_W || $bits(axis_s[gi].tuser_vendor) != USER_W) begin : g_bad_s_if
      $fatal(1, "ofs_fim_axis_rr_arb: axis_s[%0d] width does not match DATA_W/USER_W", gi);
    end
    assign req[gi]         = axis_s[gi].tvalid;
    assign last_vec[gi]    = axis_s[gi].tlast;
    assign data_arr[gi]    = axis_s[gi].tdata;
    assign keep_arr[gi]    = axis_s[gi].tkeep;
    assign user_arr[gi]    = axis_s[gi].tuser_vendor;
    // grant is zero outside LOCK, so non-owners and the idle state see no tready.
    assign axis_s[gi].tready = grant[gi] & m_ready;
  end

  ofs_fim_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  // One-hot mux of the owner's beat onto the shared output, plus owner index.
  always_comb begin
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    m_keep    = '0;
    m_user    = '0;
    owner_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) begin
        m_valid   = req[k];
        m_last    = last_vec[k];
        m_data    = data_arr[k];
        m_keep    = keep_arr[k];
        m_user    = user_arr[k];
        owner_idx = PTR_W'(k);
      end
    end
  end

  assign m_ready             = axis_m.tready;
  assign axis_m.tvalid       = m_valid;
  assign axis_m.tlast        = m_last;
  assign axis_m.tdata        = m_data;
  assign axis_m.tkeep        = m_keep;
  assign axis_m.tuser_vendor = m_user;

  assign busy     = (state == LOCK);
  assign pkt_done = busy & m_valid & m_ready & m_last;

  // Arbitration FSM: register a winner in IDLE, hold it until its tlast handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= winner;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (pkt_done) begin
            grant  <= '0;
            rr_ptr <= PTR_W'(wrap_add(int'(owner_idx), 1, NUM_PORTS));
            state  <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ofs_fim_axis_rr_arb.md
OFS_FIM_AXIS_RR_ARB -- requirements
Module: ofs_fim_axis_rr_arb

Interface
REQ-001 The block SHALL expose these parameters, one per line as name, default, meaning:
- NUM_PORTS, 2, number of requesters, legal range 2..8.
- DATA_W, 512, tdata width; SHALL equal DATA_W of every attached pcie_ss_axis_if.
- USER_W, 10, tuser_vendor width; SHALL equal USER_W of every attached pcie_ss_axis_if.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset, asynchronous assert, active-low.
- axis_s[NUM_PORTS]  pcie_ss_axis_if.sink  DATA_W/USER_W  requester streams.
- axis_m  pcie_ss_axis_if.source  DATA_W/USER_W  shared output stream.
- grant  output  NUM_PORTS  one-hot owner of axis_m; all zero when idle.
- busy  output  1  high while a packet is locked to a requester.

REQ-003 One clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 The FSM SHALL have two states: IDLE and LOCK.

REQ-005 In IDLE with at least one axis_s[i].tvalid, the block SHALL register a winner and enter LOCK on the next clock edge. The winner is the first valid index at or after rr_ptr, searching upward and wrapping modulo NUM_PORTS.

REQ-006 In IDLE, all axis_s[i].tready SHALL be 0, axis_m.tvalid SHALL be 0, and grant SHALL be 0.

REQ-007 In LOCK with owner g, the following SHALL be driven combinationally with zero added latency:
- axis_m.tvalid/tdata/tkeep/tlast/tuser_vendor = axis_s[g] fields.
- axis_s[g].tready = axis_m.tready.
- axis_s[j].tready = 0 for every j != g.

REQ-008 The block SHALL leave LOCK only on a handshake with tlast=1 (axis_s[g].tvalid & axis_m.tready & axis_s[g].tlast). On that edge it SHALL return to IDLE and set rr_ptr = (g+1) mod NUM_PORTS.

REQ-009 A packet SHALL never be interleaved with another. Beats of a locked owner SHALL pass through in order, unchanged, for any packet length including 1 beat.

REQ-010 Arbitration cost SHALL be exactly one idle cycle between packets. A single-beat packet granted at cycle t+1 completes at t+1 at the earliest.

REQ-011 Requester tvalid deassertion mid-packet (bubble) SHALL NOT release the lock. axis_m.tvalid follows axis_s[g].tvalid.

REQ-012 A requester that deasserts tvalid while IDLE, before grant, SHALL simply lose that round. The registered winner remains owner even if its tvalid drops in the first LOCK cycle.

REQ-013 When a single requester is continuously valid, it SHALL win every round. When all requesters are continuously valid, grants SHALL rotate 0,1,...,NUM_PORTS-1,0.

REQ-014 busy SHALL equal (state==LOCK). grant SHALL be the registered one-hot owner and SHALL be valid only in LOCK.

REQ-015 Backpressure (axis_m.tready=0) SHALL hold all outputs stable and SHALL NOT change owner or rr_ptr.

Reset
REQ-016 When rst_n=0, the block SHALL immediately enter this state: FSM=IDLE, rr_ptr=0, grant=0, busy=0, axis_m.tvalid=0, all axis_s[i].tready=0.

REQ-017 Reset asserted mid-packet SHALL abort the packet with no further beats forwarded. After deassertion, arbitration SHALL restart from index 0.

REQ-018 Datapath fields (tdata/tkeep/tuser_vendor/tlast) are muxed and SHALL require no reset.

Structure
REQ-019 Package ofs_fim_axis_arb_pkg SHALL hold the state enum (IDLE, LOCK) and the MAX_PORTS=8 constant.

REQ-020 Round-robin winner selection SHALL live in sub-module ofs_fim_rr_arbiter (inputs: req vector and ptr; output: one-hot winner; purely combinational). FSM, lock register and mux SHALL stay in the top.

REQ-021 An elaboration-time check SHALL fatal when NUM_PORTS is out of range or when interface DATA_W/USER_W differ from the parameters.

Verification
REQ-022 NUM_PORTS=2; port0 sends a 3-beat packet, port1 idle, tready=1 -> grant=01 from cycle 1; beats appear on cycles 1-3; busy falls at cycle 4.

REQ-023 Ports 0,1,2 all valid with 1-beat packets continuously -> grant sequence 001,000,010,000,100,000,001; beats alternate with idle cycles.

REQ-024 Port0 4-beat packet, port1 valid throughout -> no port1 beat is forwarded until after port0's tlast beat; the next grant is 10.

REQ-025 Locked packet with tready toggling 1,0,0,1 and a port0 tvalid bubble on beat 2 -> data is forwarded intact, with no owner change and no duplicated or dropped beat.

REQ-026 rst_n pulsed low during beat 2 of a 5-beat packet on port1 -> the same cycle shows tvalid=0, all tready=0 and grant=0. After release with both ports valid, port0 wins first.
